aes_encrypt_core: RTL and testbench

AES_ENCRYPT_CORE -- requirements
Module: aes_encrypt_core

---
 rtl/aes_enc_pkg.sv | 55 +++++
 rtl/SubBytes.sv | 39 +++
 rtl/aes_encrypt_core.sv | 141 ++++++++++++++
 tb/tb_aes_encrypt_core.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_enc_pkg.sv
// ---------------------------------------------------------------------------
// aes_enc_pkg
// Shared definitions for the AES-128 encryption core:
//   - aes_state_e    : FSM state encoding (IDLE, SUB, ROUND, DONE)
//   - NUM_ROUNDS     : number of AES-128 rounds (10)
//   - COLS_PER_ROUND : state columns processed by SubBytes per round (4)
//   - xtime          : multiply by x (02) in GF(2^8)
//   - gf_mul         : general GF(2^8) multiply (used by the S-box inverse)
//   - mix_column     : MixColumns applied to one 32-bit column
// No ports; compiled before every file that imports it.
// ---------------------------------------------------------------------------
package aes_enc_pkg;

  localparam int NUM_ROUNDS     = 10;
  localparam int COLS_PER_ROUND = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SUB   = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } aes_state_e;

  // Multiply by 02 modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply; each step multiplies the running operand by 02.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // Column bits [31:24] hold row 0, [7:0] hold row 3.
  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/SubBytes.sv
// ---------------------------------------------------------------------------
// SubBytes
// Combinational forward AES S-box for a single byte.
//   data_i [7:0] : input byte
//   data_o [7:0] : S(data_i)
// The multiplicative inverse is computed as x^254 with an addition chain
// (0 maps to 0 naturally), followed by the FIPS-197 affine transform.
// ---------------------------------------------------------------------------
module SubBytes
  import aes_enc_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  // Addition chain: 2,3,6,12,15,30,60,120,240,252,254.
  assign x2   = gf_mul(data_i, data_i);
  assign x3   = gf_mul(x2, data_i);
  assign x6   = gf_mul(x3, x3);
  assign x12  = gf_mul(x6, x6);
  assign x15  = gf_mul(x12, x3);
  assign x30  = gf_mul(x15, x15);
  assign x60  = gf_mul(x30, x30);
  assign x120 = gf_mul(x60, x60);
  assign x240 = gf_mul(x120, x120);
  assign x252 = gf_mul(x240, x12);
  assign inv  = gf_mul(x252, x2);

  // Affine map: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 63.
  assign data_o = inv
                ^ {inv[6:0], inv[7]}
                ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]}
                ^ 8'h63;

endmodule

// File: rtl/aes_encrypt_core.sv
// ---------------------------------------------------------------------------
// aes_encrypt_core
// Iterative AES-128 encryptor: one S-box column per cycle, then one cycle
// for ShiftRows/MixColumns/AddRoundKey, giving 5 cycles per round.
//   clk                 : clock, rising edge
//   RESET               : synchronous active-low reset
//   start               : level request; held until AES_DONE
//   plaintext   [127:0] : input block, byte 0 in [127:120]
//   keyschedule [1407:0]: expanded key, round key r at [128r+127:128r]
//   ciphertext  [127:0] : result register, held until the next final round
//   AES_DONE            : high while in DONE
//   busy                : high while in SUB or ROUND
// ---------------------------------------------------------------------------
module aes_encrypt_core
  import aes_enc_pkg::*;
(
  input  logic          clk,
  input  logic          RESET,
  input  logic          start,
  input  logic [127:0]  plaintext,
  input  logic [1407:0] keyschedule,
  output logic [127:0]  ciphertext,
  output logic          AES_DONE,
  output logic          busy
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  aes_state_e   fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] ct_q, ct_d;
  logic [3:0]   round_q, round_d;
  logic [1:0]   col_q, col_d;

  logic [31:0]  sub_in, sub_out;
  logic [127:0] shifted, mixed, round_key;

  // Column selected for substitution this cycle; column c is state[127-32c -: 32].
  always_comb begin
    sub_in = state_q[127:96];
    case (col_q)
      2'd0: sub_in = state_q[127:96];
      2'd1: sub_in = state_q[95:64];
      2'd2: sub_in = state_q[63:32];
      2'd3: sub_in = state_q[31:0];
      default: sub_in = state_q[127:96];
    endcase
  end

  genvar gi, gj;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      SubBytes u_sbox (
        .data_i (sub_in[8*gi +: 8]),
        .data_o (sub_out[8*gi +: 8])
      );
    end

    // ShiftRows: byte (row r, col c) sits at index 4c+r and takes (r, (c+r) mod 4).
    for (gi = 0; gi < COLS_PER_ROUND; gi++) begin : g_col
      for (gj = 0; gj < 4; gj++) begin : g_row
        assign shifted[127-8*(4*gi+gj) -: 8] = state_q[127-8*(4*((gi+gj)%4)+gj) -: 8];
      end
      assign mixed[127-32*gi -: 32] = mix_column(shifted[127-32*gi -: 32]);
    end
  endgenerate

  // round_q never exceeds 10, so the slice stays inside the 1408-bit key.
  assign round_key = keyschedule[{round_q, 7'd0} +: 128];

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    ct_d    = ct_q;
    round_d = round_q;
    col_d   = col_q;
    case (fsm_q)
      ST_IDLE: begin
        if (start) begin
          state_d = plaintext ^ keyschedule[127:0];
          round_d = 4'd1;
          col_d   = 2'd0;
          fsm_d   = ST_SUB;
        end
      end
      ST_SUB: begin
        case (col_q)
          2'd0: state_d[127:96] = sub_out;
          2'd1: state_d[95:64]  = sub_out;
          2'd2: state_d[63:32]  = sub_out;
          2'd3: state_d[31:0]   = sub_out;
          default: state_d = state_q;
        endcase
        // 2-bit counter wraps from 3 back to 0 on its own.
        col_d = col_q + 2'd1;
        if (col_q == 2'd3) fsm_d = ST_ROUND;
      end
      ST_ROUND: begin
        if (round_q >= LAST_ROUND) begin
          state_d = shifted ^ round_key;
          ct_d    = shifted ^ round_key;
          round_d = 4'd0;
          fsm_d   = ST_DONE;
        end else begin
          state_d = mixed ^ round_key;
          round_d = round_q + 4'd1;
          fsm_d   = ST_SUB;
        end
      end
      ST_DONE: begin
        if (!start) fsm_d = ST_IDLE;
      end
      default: begin
        fsm_d   = ST_IDLE;
        round_d = 4'd0;
        col_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RESET) begin
      fsm_q   <= ST_IDLE;
      state_q <= 128'h0;
      ct_q    <= 128'h0;
      round_q <= 4'd0;
      col_q   <= 2'd0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      ct_q    <= ct_d;
      round_q <= round_d;
      col_q   <= col_d;
    end
  end

  assign ciphertext = ct_q;
  assign AES_DONE   = (fsm_q == ST_DONE);
  assign busy       = (fsm_q == ST_SUB) || (fsm_q == ST_ROUND);

endmodule

// File: tb/tb_aes_encrypt_core.sv
// ---------------------------------------------------------------------------
// tb_aes_encrypt_core
// Self-checking bench for aes_encrypt_core: FIPS-197 vectors, back-to-back
// runs, reset mid-run, start held in DONE, and randomized keys/blocks
// checked against a byte-array AES-128 reference model.
// ---------------------------------------------------------------------------
module tb_aes_encrypt_core;

  logic          clk;
  logic          RESET;
  logic          start;
  logic [127:0]  plaintext;
  logic [1407:0] keyschedule;
  logic [127:0]  ciphertext;
  logic          AES_DONE;
  logic          busy;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] sbox_t [256];

  aes_encrypt_core dut (
    .clk         (clk),
    .RESET       (RESET),
    .start       (start),
    .plaintext   (plaintext),
    .keyschedule (keyschedule),
    .ciphertext  (ciphertext),
    .AES_DONE    (AES_DONE),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  // Carry-less product followed by polynomial reduction by 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'h0;
    for (int i = 0; i < 8; i++)
      if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
    return prod[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [1407:0] expand_key(input logic [127:0] key);
    logic [31:0]   w [44];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] ks;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      ks[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [1407:0] ks, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] rk, out;
    logic [7:0]   a0, a1, a2, a3;
    rk = ks[127:0];
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c+r] = s[4*((c+r)%4)+r];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      rk = ks[128*rnd +: 128];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) out[127-8*i -: 8] = s[i];
    return out;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Starts one encryption and follows it to DONE. Plaintext is overwritten
  // with all-ones at edge 5; with noisy set, start toggles while busy.
  task automatic run_txn(input string tag, input logic [1407:0] ks, input logic [127:0] pt,
                         input logic [127:0] exp_ct, input bit noisy,
                         input bit chk_hold, input logic [127:0] hold_ct);
    int edges, busy_err, hold_err;
    bit seen;
    edges = 0; busy_err = 0; hold_err = 0; seen = 0;
    @(negedge clk);
    start = 1'b1; plaintext = pt; keyschedule = ks;
    @(posedge clk);
    @(negedge clk);
    if (!busy || AES_DONE) busy_err++;
    while (!seen && edges < 200) begin
      if (noisy && edges < 45) start = 1'($urandom_range(0, 1));
      else start = 1'b1;
      if (edges == 5) plaintext = '1;
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (AES_DONE) seen = 1;
      else begin
        if (!busy) busy_err++;
        if (chk_hold && ciphertext !== hold_ct) hold_err++;
      end
    end
    chk({tag, " latency"}, 128'(edges), 128'd50);
    chk({tag, " busy_run"}, 128'(busy_err), 128'd0);
    chk({tag, " busy_at_done"}, 128'(busy), 128'd0);
    chk({tag, " ct"}, ciphertext, exp_ct);
    if (chk_hold) chk({tag, " ct_hold"}, 128'(hold_err), 128'd0);
    $display("txn %s: pt=%h ct=%h exp=%h edges=%0d", tag, pt, ciphertext, exp_ct, edges);
  endtask

  task automatic drop_start(input string tag, input logic [127:0] held);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, " idle_done"}, 128'(AES_DONE), 128'd0);
    chk({tag, " idle_busy"}, 128'(busy), 128'd0);
    chk({tag, " idle_ct"}, ciphertext, held);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [1407:0] ks_a, ks_b, ks_r;
    logic [127:0]  pt_a, pt_b, ct_a, ct_b, key_r, pt_r, exp_r;
    int            err;

    RESET = 1'b0; start = 1'b0; plaintext = '0; keyschedule = '0;
    build_sbox();
    ks_a = expand_key(128'h000102030405060708090a0b0c0d0e0f);
    ks_b = expand_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    pt_a = 128'h00112233445566778899aabbccddeeff;
    pt_b = 128'h3243f6a8885a308d313198a2e0370734;
    ct_a = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    ct_b = 128'h3925841d02dc09fbdc118597196a0b32;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst ct", ciphertext, 128'h0);
    chk("rst done", 128'(AES_DONE), 128'd0);
    chk("rst busy", 128'(busy), 128'd0);
    RESET = 1'b1;

    // FIPS-197 C.1, then B back-to-back with a one-cycle gap.
    run_txn("c1", ks_a, pt_a, ct_a, 1'b0, 1'b0, 128'h0);
    drop_start("c1", ct_a);
    run_txn("b_b2b", ks_b, pt_b, ct_b, 1'b0, 1'b1, ct_a);

    // Start held in DONE for 20 cycles: no rerun, outputs stable.
    err = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (!AES_DONE) err++;
      if (busy) err++;
      if (ciphertext !== ct_b) err++;
    end
    chk("hold_done20", 128'(err), 128'd0);
    drop_start("b", ct_b);

    // Reset at edge 23 of a C.1 run.
    @(negedge clk);
    start = 1'b1; plaintext = pt_a; keyschedule = ks_a;
    @(posedge clk);
    for (int k = 1; k < 23; k++) @(posedge clk);
    @(negedge clk);
    chk("pre_rst busy", 128'(busy), 128'd1);
    RESET = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst ct", ciphertext, 128'h0);
    chk("midrst busy", 128'(busy), 128'd0);
    chk("midrst done", 128'(AES_DONE), 128'd0);
    // Reset on the same edge as a would-be start acceptance.
    @(posedge clk);
    @(negedge clk);
    chk("rst_start busy", 128'(busy), 128'd0);
    RESET = 1'b1; start = 1'b0;
    run_txn("c1_after_rst", ks_a, pt_a, ct_a, 1'b0, 1'b0, 128'h0);
    drop_start("c1r", ct_a);

    // Randomized keys and blocks against the reference model.
    for (int n = 0; n < 8; n++) begin
      key_r = {$urandom, $urandom, $urandom, $urandom};
      pt_r  = {$urandom, $urandom, $urandom, $urandom};
      ks_r  = expand_key(key_r);
      exp_r = ref_encrypt(ks_r, pt_r);
      run_txn($sformatf("rnd%0d", n), ks_r, pt_r, exp_r, 1'b1, 1'b0, 128'h0);
      drop_start($sformatf("rnd%0d", n), exp_r);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
